clock_mode_ctrl: RTL
====================

// Module: clock_mode_ctrl
// PURPOSE
//  Mode/set sequencer for the digital clock. It debounces the 4 raw buttons and runs the
//  display/set FSM. It gates the 1 Hz tick into the time counter, issues the midnight
//  day-advance pulse to the date handler, and issues one-cycle field-increment pulses to
//  the time and date handlers while the user sets them.
// PARAMETERS
//  DEB_CYCLES   4   consecutive stable synced samples needed to change a debounced level
//  TIMEOUT_SEC  10  idle seconds in a SET state before auto-exit (AUTO_EXIT_EN only)
// PORTS
//  clk        in   1  system clock
//  rst        in   1  asynchronous, active-high reset
//  tick_1hz   in   1  one-cycle pulse per second
//  btn        in   4  raw buttons: [0]=MODE [1]=INC [2]=EXIT [3]=DISP
//  hr,min,sec in   6  current time, binary (0-23 / 0-59 / 0-59)
//  time_enb   out  1  tick forwarded to the time counter
//  day_adv    out  1  midnight pulse to the date handler
//  inc_hr,inc_min,inc_mon,inc_day  out 1 each  one-cycle field-increment pulses
//  disp_date  out  1  1 = show MM/DD, 0 = show HH:MM
//  set_mode   out  1  1 while in any SET state
//  field      out  2  field being edited: 0=HR 1=MIN 2=MON 3=DAY (0 in RUN states)
//  blink      out  1  blink phase for the field being edited
// BEHAVIOUR
//  Reset: state=RUN_TIME; sync flops, debounced levels, counters and all outputs = 0.
//   A button held through reset deassertion yields one press after debounce.
//  Input path per button:
//   - 2-flop synchronizer, then a counter: the debounced level takes the synced value
//     after DEB_CYCLES consecutive samples that differ from the current level.
//   - Press event = rising edge of the debounced level, one clk wide.
//   - Release generates nothing. Holding a button gives one event, no auto-repeat.
//  Latency: all outputs are registered. A pulse/state change appears 1 clk after its press event.
//  Event priority in one cycle: EXIT > MODE > INC > DISP. Only the highest valid event acts.
//  FSM states and transitions:
//   - RUN_TIME: DISP -> RUN_DATE; MODE -> SET_HR.
//   - RUN_DATE: DISP -> RUN_TIME; MODE -> SET_HR.
//   - SET_HR -MODE-> SET_MIN -MODE-> SET_MON -MODE-> SET_DAY -MODE-> RUN_TIME.
//   - Any SET state: EXIT -> RUN_TIME.
//   - EXIT in RUN states, and DISP in SET states, are ignored.
//  INC: in SET_x, inc_x = 1 for exactly one clk; ignored in RUN states. Range wrap and
//   month-length clamping belong to the handlers, not to this block.
//  Outputs by state:
//   - time_enb = tick_1hz registered, in RUN states only. Forced 0 in SET states (time frozen).
//   - day_adv = 1 in the same cycle as time_enb when hr==23 && min==59 && sec==59.
//     Never asserted in SET states.
//   - disp_date = 1 in RUN_DATE, SET_MON and SET_DAY.
//   - set_mode and field follow the state.
//   - blink toggles on each tick_1hz in SET states. It is cleared to 0 on entering any
//     state and held at 0 in RUN states.
//  Mid-operation reset: returns to RUN_TIME at once. Any pulse in flight is dropped.
// CONFIGURATION
//  AUTO_EXIT_EN defined:
//   - A 4-bit idle counter counts tick_1hz in SET states.
//   - It clears on entering a SET state and on every press event.
//   - When it reaches TIMEOUT_SEC, the FSM goes to RUN_TIME on the next clk.
//   - An EXIT/MODE event in that same cycle takes priority over the timeout.
//  AUTO_EXIT_EN undefined: SET states persist indefinitely. TIMEOUT_SEC is unused and
//   no counter logic is built.
// TESTING
//  1 Debounce: btn[0] glitch 1..DEB_CYCLES-1 clks -> no state change. Held 20 clks ->
//    SET_HR exactly DEB_CYCLES+4 clks after the rising edge, set_mode=1, field=0.
//  2 Set walk: from RUN_TIME press MODE x4 with one INC in each state -> one pulse each on
//    inc_hr, inc_min, inc_mon, inc_day in that order, then RUN_TIME.
//  3 Midnight: RUN_TIME, hr=23 min=59 sec=59, tick_1hz -> time_enb=1 and day_adv=1 in the
//    same clk. Repeat in SET_MIN -> both stay 0.
//  4 Priority: EXIT+INC same cycle in SET_MIN -> RUN_TIME, inc_min stays 0. DISP in SET_HR
//    -> ignored. EXIT in RUN_DATE -> ignored.
//  5 Reset mid-set: assert rst in SET_MON while inc_mon is high -> all outputs 0, RUN_TIME.
//    btn[1] held through reset -> no inc pulse, since INC is ignored in RUN_TIME.
//  6 AUTO_EXIT_EN: enter SET_DAY, idle 10 ticks -> RUN_TIME. An INC at tick 9 restarts the
//    count (exit at tick 19). Without the macro -> still SET_DAY after 20 ticks.

Source files
------------

// File: rtl/clock_mode_ctrl.sv
// rtl/clock_mode_ctrl.sv - Mode/set sequencer for the digital clock
//
// Debounces the four raw buttons, runs the display/set FSM, gates the 1 Hz
// tick into the time counter, raises the midnight day-advance pulse and emits
// one-cycle field-increment pulses while the user edits a field.
//
// Optional feature macro: AUTO_EXIT_EN (idle timeout leaves any SET state).
//
// Ports:
//   clk        system clock
//   rst        asynchronous active-high reset
//   tick_1hz   one-cycle pulse per second
//   btn[3:0]   raw buttons: [0]=MODE [1]=INC [2]=EXIT [3]=DISP
//   hr/min/sec current time, binary
//   time_enb   registered tick forwarded to the time counter (RUN states)
//   day_adv    midnight pulse, coincident with time_enb at 23:59:59
//   inc_hr/inc_min/inc_mon/inc_day  one-cycle field-increment pulses
//   disp_date  1 = show MM/DD, 0 = show HH:MM
//   set_mode   1 while in any SET state
//   field      field being edited: 0=HR 1=MIN 2=MON 3=DAY (0 in RUN states)
//   blink      blink phase for the edited field

module clock_mode_ctrl #(
  parameter int DEB_CYCLES  = 4,
  parameter int TIMEOUT_SEC = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_1hz,
  input  logic [3:0] btn,
  input  logic [5:0] hr,
  input  logic [5:0] min,
  input  logic [5:0] sec,
  output logic       time_enb,
  output logic       day_adv,
  output logic       inc_hr,
  output logic       inc_min,
  output logic       inc_mon,
  output logic       inc_day,
  output logic       disp_date,
  output logic       set_mode,
  output logic [1:0] field,
  output logic       blink
);

  localparam int CW = $clog2(DEB_CYCLES + 1);

  typedef enum logic [2:0] {
    RUN_TIME = 3'd0,
    RUN_DATE = 3'd1,
    SET_HR   = 3'd2,
    SET_MIN  = 3'd3,
    SET_MON  = 3'd4,
    SET_DAY  = 3'd5
  } state_t;

  state_t state, next_state;

  logic [3:0]         sync1, sync2, level, level_d, press;
  logic [3:0][CW-1:0] deb_cnt;
  logic [3:0]         inc_next;
  logic               timeout;

  // ---------------------------------------------------------------------
  // Button input path: synchronizer, debounce counter, registered edge.
  // The edge is registered so a state change lands DEB_CYCLES+4 clocks
  // after the raw rising edge.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1   <= '0;
      sync2   <= '0;
      level   <= '0;
      level_d <= '0;
      press   <= '0;
      deb_cnt <= '0;
    end else begin
      sync1   <= btn;
      sync2   <= sync1;
      level_d <= level;
      press   <= level & ~level_d;
      for (int i = 0; i < 4; i++) begin
        if (sync2[i] == level[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == CW'(DEB_CYCLES - 1)) begin
          level[i]   <= sync2[i];
          deb_cnt[i] <= '0;
        end else begin
          deb_cnt[i] <= deb_cnt[i] + 1'b1;
        end
      end
    end
  end

  wire ev_mode = press[0];
  wire ev_inc  = press[1];
  wire ev_exit = press[2];
  wire ev_disp = press[3];

  function automatic logic is_set(input state_t s);
    return (s != RUN_TIME) && (s != RUN_DATE);
  endfunction

  function automatic logic [1:0] field_of(input state_t s);
    case (s)
      SET_MIN: return 2'd1;
      SET_MON: return 2'd2;
      SET_DAY: return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

  function automatic logic shows_date(input state_t s);
    return (s == RUN_DATE) || (s == SET_MON) || (s == SET_DAY);
  endfunction

  // ---------------------------------------------------------------------
  // Idle timeout
  // ---------------------------------------------------------------------
`ifdef AUTO_EXIT_EN
  logic [3:0] idle_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idle_cnt <= '0;
    end else if (!is_set(next_state) || (next_state != state) || (|press)) begin
      idle_cnt <= '0;
    end else if (tick_1hz && (idle_cnt != 4'(TIMEOUT_SEC))) begin
      idle_cnt <= idle_cnt + 4'd1;
    end
  end

  assign timeout = (idle_cnt == 4'(TIMEOUT_SEC));
`else
  assign timeout = 1'b0;
  logic unused_timeout_sec;
  assign unused_timeout_sec = (TIMEOUT_SEC > 0);
`endif

  // ---------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= RUN_TIME;
    else     state <= next_state;
  end

  // Events that are meaningless in the current state are skipped, so the
  // highest-priority event that is valid here is the one that acts.
  always_comb begin
    next_state = state;
    inc_next   = 4'b0000;
    case (state)
      RUN_TIME: begin
        if (ev_mode)      next_state = SET_HR;
        else if (ev_disp) next_state = RUN_DATE;
      end
      RUN_DATE: begin
        if (ev_mode)      next_state = SET_HR;
        else if (ev_disp) next_state = RUN_TIME;
      end
      SET_HR, SET_MIN, SET_MON, SET_DAY: begin
        if (ev_exit) begin
          next_state = RUN_TIME;
        end else if (ev_mode) begin
          case (state)
            SET_HR:  next_state = SET_MIN;
            SET_MIN: next_state = SET_MON;
            SET_MON: next_state = SET_DAY;
            default: next_state = RUN_TIME;
          endcase
        end else if (ev_inc) begin
          // inc_next bit order: [3]=hr [2]=min [1]=mon [0]=day
          inc_next[3 - field_of(state)] = 1'b1;
        end else if (timeout) begin
          next_state = RUN_TIME;
        end
      end
      default: next_state = RUN_TIME;
    endcase
  end

  // ---------------------------------------------------------------------
  // Registered outputs. State-derived outputs are decoded from next_state
  // so they change in the same clock as the state register.
  // ---------------------------------------------------------------------
  wire run_now  = !is_set(state);
  wire midnight = (hr == 6'd23) && (min == 6'd59) && (sec == 6'd59);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      time_enb  <= 1'b0;
      day_adv   <= 1'b0;
      inc_hr    <= 1'b0;
      inc_min   <= 1'b0;
      inc_mon   <= 1'b0;
      inc_day   <= 1'b0;
      disp_date <= 1'b0;
      set_mode  <= 1'b0;
      field     <= 2'd0;
      blink     <= 1'b0;
    end else begin
      time_enb  <= tick_1hz & run_now;
      day_adv   <= tick_1hz & run_now & midnight;
      inc_hr    <= inc_next[3];
      inc_min   <= inc_next[2];
      inc_mon   <= inc_next[1];
      inc_day   <= inc_next[0];
      disp_date <= shows_date(next_state);
      set_mode  <= is_set(next_state);
      field     <= field_of(next_state);
      // Any state change restarts the blink phase at 0.
      if ((next_state != state) || !is_set(next_state)) blink <= 1'b0;
      else if (tick_1hz)                                blink <= ~blink;
    end
  end

endmodule
